// File: rtl/bru_pkg.sv
// bru_pkg: shared definitions for the branch resolution unit.
//   bru_state_e  - resolver FSM state encoding (RUN / SHADOW)
//   XLEN_DEFAULT - default PC / target width
package bru_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } bru_state_e;

endpackage

// File: rtl/bru_perf_cnt.sv
// bru_perf_cnt: resolved-CTI and mispredict event counters.
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-low reset
//   inc_branch     - count one resolved control transfer
//   inc_mispredict - count one mispredict
//   branches       - resolved control-transfer count (wraps at 2^32)
//   mispredicts    - mispredict count (wraps at 2^32)
module bru_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_branch,
    input  logic        inc_mispredict,
    output logic [31:0] branches,
    output logic [31:0] mispredicts
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            branches    <= '0;
            mispredicts <= '0;
        end else begin
            if (inc_branch)     branches    <= branches + 32'd1;
            if (inc_mispredict) mispredicts <= mispredicts + 32'd1;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage resolution of conditional branches, JAL and JALR.
// Compares the fetch-time prediction with the real outcome, writes the BTB,
// and on a mispredict issues a registered redirect plus IF/ID and ID/EX
// flushes, then ignores the single wrong-path instruction that follows.
//
// Optional feature: define BRU_PERF_CNT_EN to build the performance counters;
// otherwise perf_branches / perf_mispredicts are tied to zero.
//
// Ports:
//   clk, rst (sync, active-low)
//   ex_* inputs     - decoded EX instruction, outcome and fetch prediction
//   update*         - BTB write strobe / index PC / target
//   redirect*       - fetch redirect strobe and corrected PC
//   flush_if_id/id_ex - pipeline flushes (same timing as redirect)
//   perf_*          - event counters
//
// FSM states:
//   state     | meaning
//   ST_RUN    | resolving normally
//   ST_SHADOW | cycle after a mispredict; EX holds a wrong-path instruction
module branch_resolve
    import bru_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_valid,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            update,
    output logic [XLEN-1:0] update_PC,
    output logic [XLEN-1:0] update_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_PC,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);

    bru_state_e      state;
    bru_state_e      state_nxt;

    logic            cti;
    logic            jalr_eff;
    logic            act_taken;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] act_next;
    logic [XLEN-1:0] pred_next;
    logic            resolve;
    logic            mispredict;
    logic            wr;

    // Outcome datapath. JAL outranks JALR, so the JALR low-bit clear only
    // applies when JAL is not also flagged.
    assign cti       = ex_is_branch | ex_is_jal | ex_is_jalr;
    assign jalr_eff  = ex_is_jalr & ~ex_is_jal;
    assign tgt       = jalr_eff ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
    assign act_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_taken);
    assign pc_plus4  = ex_pc + XLEN'(4);
    assign act_next  = act_taken ? tgt : pc_plus4;
    assign pred_next = ex_pred_valid ? ex_pred_target : pc_plus4;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (mispredict) state_nxt = ST_SHADOW;
            ST_SHADOW: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Output decode: nothing resolves while in the shadow of a redirect.
    always_comb begin
        resolve    = 1'b0;
        mispredict = 1'b0;
        wr         = 1'b0;
        if (state == ST_RUN) begin
            resolve    = ex_valid & cti;
            mispredict = resolve & (act_next != pred_next);
            // Not-taken outcomes never write: the BTB cannot invalidate.
            wr         = resolve & act_taken &
                         (~ex_pred_valid | (ex_pred_target != tgt));
        end
    end

    // Registered outputs; the PC/target fields hold until the next capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            update        <= 1'b0;
            update_PC     <= '0;
            update_target <= '0;
            redirect      <= 1'b0;
            redirect_PC   <= '0;
        end else begin
            update   <= wr;
            redirect <= mispredict;
            if (wr) begin
                update_PC     <= ex_pc;
                update_target <= tgt;
            end
            if (mispredict) redirect_PC <= act_next;
        end
    end

    assign flush_if_id = redirect;
    assign flush_id_ex = redirect;

`ifdef BRU_PERF_CNT_EN
    bru_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .inc_branch     (resolve),
        .inc_mispredict (mispredict),
        .branches       (perf_branches),
        .mispredicts    (perf_mispredicts)
    );
`else
    assign perf_branches    = 32'd0;
    assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
    logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
    logic        ex_taken = 1'b0, ex_pred_valid = 1'b0;
    logic        update, redirect, flush_if_id, flush_id_ex;
    logic [31:0] update_PC, update_target, redirect_PC, perf_branches, perf_mispredicts;

    branch_resolve #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_valid(ex_pred_valid),
        .ex_pred_target(ex_pred_target),
        .update(update), .update_PC(update_PC), .update_target(update_target),
        .redirect(redirect), .redirect_PC(redirect_PC),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the outputs should read after each edge.
    bit          m_ignore_next;
    bit          m_upd, m_red;
    logic [31:0] m_upd_pc, m_upd_tgt, m_red_pc, m_br, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit v, input bit br, input bit jal, input bit jalr,
                          input bit tk, input logic [31:0] pc, input logic [31:0] tg,
                          input bit pv, input logic [31:0] pt);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_taken = tk; ex_pc = pc; ex_target = tg; ex_pred_valid = pv; ex_pred_target = pt;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    // One clock: derive the architectural outcome from the instruction's
    // meaning, advance the edge, update the model and compare every output.
    task automatic cycle();
        bit          taken, live, mis, wr, rst_s;
        logic [31:0] tgt, nxt_actual, nxt_pred;
        rst_s = rst;
        if (ex_is_jal)       begin taken = 1; tgt = ex_target; end
        else if (ex_is_jalr) begin taken = 1; tgt = ex_target & ~32'h1; end
        else                 begin taken = ex_is_branch & ex_taken; tgt = ex_target; end
        nxt_actual = taken ? tgt : ex_pc + 32'd4;
        nxt_pred   = ex_pred_valid ? ex_pred_target : ex_pc + 32'd4;
        live = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr) && !m_ignore_next;
        mis  = live && (nxt_actual != nxt_pred);
        wr   = live && taken && (!ex_pred_valid || ex_pred_target != tgt);
        @(posedge clk);
        #1;
        if (!rst_s) begin
            m_ignore_next = 0; m_upd = 0; m_red = 0;
            m_upd_pc = 0; m_upd_tgt = 0; m_red_pc = 0; m_br = 0; m_mis = 0;
        end else begin
            m_upd = wr;
            m_red = mis;
            if (wr)  begin m_upd_pc = ex_pc; m_upd_tgt = tgt; end
            if (mis) m_red_pc = nxt_actual;
            if (live) m_br = m_br + 1;
            if (mis)  m_mis = m_mis + 1;
            m_ignore_next = mis;
        end
        chk("update", {31'b0, update}, {31'b0, m_upd});
        chk("redirect", {31'b0, redirect}, {31'b0, m_red});
        chk("flush_if_id", {31'b0, flush_if_id}, {31'b0, m_red});
        chk("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, m_red});
        chk("update_PC", update_PC, m_upd_pc);
        chk("update_target", update_target, m_upd_tgt);
        chk("redirect_PC", redirect_PC, m_red_pc);
`ifdef BRU_PERF_CNT_EN
        chk("perf_branches", perf_branches, m_br);
        chk("perf_mispredicts", perf_mispredicts, m_mis);
`else
        chk("perf_branches", perf_branches, 32'd0);
        chk("perf_mispredicts", perf_mispredicts, 32'd0);
`endif
    endtask

    typedef struct {
        string       name;
        bit          v, br, jal, jalr, tk, pv;
        logic [31:0] pc, tg, pt;
        bit          e_upd, e_red;
        logic [31:0] e_upd_pc, e_upd_tgt, e_red_pc;
        int          d_br, d_mis;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] br0, mis0;
        vecs[0] = '{"jal_miss",     1,0,1,0,0, 0, 32'h100, 32'h200, 32'h0,  1,1, 32'h100, 32'h200, 32'h200, 1,1};
        vecs[1] = '{"beq_hit",      1,1,0,0,1, 1, 32'h80,  32'h40,  32'h40, 0,0, 0, 0, 0, 1,0};
        vecs[2] = '{"bne_stale",    1,1,0,0,0, 1, 32'h40,  32'h10,  32'h10, 0,1, 0, 0, 32'h44, 1,1};
        vecs[3] = '{"jalr_lsb",     1,0,0,1,0, 0, 32'h300, 32'h401, 32'h0,  1,1, 32'h300, 32'h400, 32'h400, 1,1};
        vecs[4] = '{"jalr_hit",     1,0,0,1,0, 1, 32'h300, 32'h401, 32'h400,0,0, 0, 0, 0, 1,0};
        vecs[5] = '{"br_nt_nopred", 1,1,0,0,0, 0, 32'h500, 32'h900, 32'h0,  0,0, 0, 0, 0, 1,0};
        vecs[6] = '{"br_wrong_tgt", 1,1,0,0,1, 1, 32'h520, 32'h600, 32'h500,1,1, 32'h520, 32'h600, 32'h600, 1,1};
        vecs[7] = '{"jal_over_jalr",1,0,1,1,0, 0, 32'h700, 32'h801, 32'h0,  1,1, 32'h700, 32'h801, 32'h801, 1,1};
        vecs[8] = '{"pc_wrap",      1,1,0,0,0, 1, 32'hFFFFFFFC, 32'h40, 32'h0, 0,0, 0, 0, 0, 1,0};
        vecs[9] = '{"not_valid",    0,0,1,0,0, 0, 32'h900, 32'hA00, 32'h0,  0,0, 0, 0, 0, 0,0};

        m_ignore_next = 0; m_upd = 0; m_red = 0;
        m_upd_pc = 0; m_upd_tgt = 0; m_red_pc = 0; m_br = 0; m_mis = 0;

        // Reset
        rst = 0; idle();
        cycle(); cycle();
        rst = 1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            br0 = perf_branches; mis0 = perf_mispredicts;
            set_in(vecs[i].v, vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].tk,
                   vecs[i].pc, vecs[i].tg, vecs[i].pv, vecs[i].pt);
            cycle();
            chk({vecs[i].name, ".update"}, {31'b0, update}, {31'b0, vecs[i].e_upd});
            chk({vecs[i].name, ".redirect"}, {31'b0, redirect}, {31'b0, vecs[i].e_red});
            chk({vecs[i].name, ".flush"}, {30'b0, flush_if_id, flush_id_ex}, {30'b0, vecs[i].e_red, vecs[i].e_red});
            if (vecs[i].e_upd) begin
                chk({vecs[i].name, ".update_PC"}, update_PC, vecs[i].e_upd_pc);
                chk({vecs[i].name, ".update_target"}, update_target, vecs[i].e_upd_tgt);
            end
            if (vecs[i].e_red) chk({vecs[i].name, ".redirect_PC"}, redirect_PC, vecs[i].e_red_pc);
`ifdef BRU_PERF_CNT_EN
            chk({vecs[i].name, ".d_branches"}, perf_branches - br0, vecs[i].d_br);
            chk({vecs[i].name, ".d_mispredicts"}, perf_mispredicts - mis0, vecs[i].d_mis);
`endif
            idle();
            cycle();
            chk({vecs[i].name, ".pulse_end"}, {30'b0, update, redirect}, 32'd0);
        end

        // Shadow: mispredict at N, mispredicting JAL at N+1 ignored, JAL at N+2 resolves.
        set_in(1, 0, 1, 0, 0, 32'h1000, 32'h2000, 0, 32'h0);
        cycle();
        chk("shadow.first_redirect", {31'b0, redirect}, 32'd1);
        set_in(1, 0, 1, 0, 0, 32'h1100, 32'h2100, 0, 32'h0);
        cycle();
        chk("shadow.ignored", {29'b0, update, redirect, flush_if_id}, 32'd0);
        chk("shadow.hold_redirect_PC", redirect_PC, 32'h2000);
        set_in(1, 0, 1, 0, 0, 32'h1200, 32'h2200, 0, 32'h0);
        cycle();
        chk("shadow.resume_redirect", {30'b0, update, redirect}, 32'd3);
        chk("shadow.resume_PC", redirect_PC, 32'h2200);
        idle(); cycle();

        // Reset asserted during SHADOW, then a missed JAL right after release.
        set_in(1, 0, 1, 0, 0, 32'h3000, 32'h4000, 0, 32'h0);
        cycle();
        rst = 0;
        cycle();
        chk("rst_shadow.pulses", {28'b0, update, redirect, flush_if_id, flush_id_ex}, 32'd0);
        chk("rst_shadow.redirect_PC", redirect_PC, 32'd0);
        chk("rst_shadow.update_target", update_target, 32'd0);
        rst = 1;
        set_in(1, 0, 1, 0, 0, 32'h3100, 32'h4100, 0, 32'h0);
        cycle();
        chk("rst_release.redirect", {30'b0, update, redirect}, 32'd3);
        chk("rst_release.redirect_PC", redirect_PC, 32'h4100);
        idle(); cycle();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          kind;
            logic [31:0] pc, tg, pt;
            bit          pv;
            kind = $urandom_range(0, 7);
            pc = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFFFFFC;
            tg = {24'b0, 8'($urandom_range(0, 255))};
            pv = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: pt = tg;
                1: pt = tg & ~32'h1;
                2: pt = pc + 32'd4;
                default: pt = $urandom;
            endcase
            set_in($urandom_range(0, 5) != 0,
                   kind inside {[3:5]} || (kind == 7 && $urandom_range(0, 1) == 1),
                   kind inside {[0:1]} || (kind == 7 && $urandom_range(0, 1) == 1),
                   kind == 2 || (kind == 7 && $urandom_range(0, 1) == 1),
                   $urandom_range(0, 1), pc, tg, pv, pt);
            if ($urandom_range(0, 199) == 0) rst = 0;
            cycle();
            rst = 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
